// File: rtl/snake_pkg.sv
// Shared snake game definitions: direction codes and direction helpers,
// used by the move controller and the snake engine.
package snake_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_DOWN  = 3'd3,
    DIR_LEFT  = 3'd4
  } dir_e;

  function automatic logic [2:0] opposite_dir(input logic [2:0] d);
    case (d)
      DIR_UP:    opposite_dir = DIR_DOWN;
      DIR_RIGHT: opposite_dir = DIR_LEFT;
      DIR_DOWN:  opposite_dir = DIR_UP;
      DIR_LEFT:  opposite_dir = DIR_RIGHT;
      default:   opposite_dir = DIR_NONE;
    endcase
  endfunction

  // Buttons {up,right,down,left}; up wins over right over down over left.
  function automatic logic [2:0] prio_dir(input logic [3:0] b);
    if (b[3])      prio_dir = DIR_UP;
    else if (b[2]) prio_dir = DIR_RIGHT;
    else if (b[1]) prio_dir = DIR_DOWN;
    else if (b[0]) prio_dir = DIR_LEFT;
    else           prio_dir = DIR_NONE;
  endfunction

endpackage

// File: rtl/snake_debounce.sv
// One button bit: 2-flop synchronizer, stability counter and rising-edge detect.
// o_press is high for one cycle, 2 + DEBOUNCE_CYCLES + 1 edges after a stable press.
module snake_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_db;
  logic          r_db_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_db   <= 1'b0;
      r_db_d <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_db_d <= r_db;
      // Any agreeing sample restarts the stability run.
      if (r_sync[1] != r_db) begin
        if (r_cnt == LAST_CNT) begin
          r_db  <= r_sync[1];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_db & ~r_db_d;

endmodule

// File: rtl/snake_move_ctrl.sv
// Per-player move queue: debounced presses are filtered against the last queued
// direction and popped into dir_out on tick; full or reversing presses pulse drop.
module snake_move_ctrl
  import snake_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int QUEUE_DEPTH     = 2,
  parameter int INIT_DIR        = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [4*NUM_PLAYERS-1:0] i_btn,
  input  logic                     i_tick,
  input  logic                     i_enable,
  output logic [3*NUM_PLAYERS-1:0] o_dir_out,
  output logic [NUM_PLAYERS-1:0]   o_q_empty,
  output logic [NUM_PLAYERS-1:0]   o_drop_pulse
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(QUEUE_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_DEPTH);

  logic [4*NUM_PLAYERS-1:0] w_press;

  for (genvar b = 0; b < 4*NUM_PLAYERS; b++) begin : g_dbn
    snake_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_btn  (i_btn[b]),
      .o_press(w_press[b])
    );
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [2:0]    r_dir;
    logic [2:0]    r_q [QUEUE_DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_cnt;
    logic          r_drop;

    logic [2:0]    w_req;
    logic [2:0]    w_ref;
    logic [PW-1:0] w_tail;
    logic [PW-1:0] w_rd_nxt;
    logic [PW-1:0] w_wr_nxt;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    always_comb begin
      w_empty  = (r_cnt == '0);
      w_full   = (r_cnt == FULL_CNT);
      w_tail   = (r_wr == '0) ? LAST_PTR : r_wr - 1'b1;
      w_rd_nxt = (r_rd == LAST_PTR) ? '0 : r_rd + 1'b1;
      w_wr_nxt = (r_wr == LAST_PTR) ? '0 : r_wr + 1'b1;
      // Filtering is against the move the snake will be making when this one runs.
      w_ref    = w_empty ? r_dir : r_q[w_tail];
      w_req    = prio_dir(w_press[4*p +: 4]);
      w_pop    = i_enable & i_tick & ~w_empty;
      w_push   = 1'b0;
      w_drop   = 1'b0;
      if (i_enable && (w_req != DIR_NONE) && (w_req != w_ref)) begin
        if ((w_req == opposite_dir(w_ref)) || (w_full && !w_pop)) w_drop = 1'b1;
        else                                                      w_push = 1'b1;
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_dir  <= 3'(INIT_DIR);
        r_rd   <= '0;
        r_wr   <= '0;
        r_cnt  <= '0;
        r_drop <= 1'b0;
      end else begin
        r_drop <= w_drop;
        if (!i_enable) begin
          r_rd  <= '0;
          r_wr  <= '0;
          r_cnt <= '0;
        end else begin
          if (w_pop) begin
            r_dir <= r_q[r_rd];
            r_rd  <= w_rd_nxt;
          end
          if (w_push) r_wr <= w_wr_nxt;
          case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: ;
          endcase
        end
      end
    end

    always_ff @(posedge i_clk) begin
      if (w_push) r_q[r_wr] <= w_req;
    end

    assign o_dir_out[3*p +: 3] = r_dir;
    assign o_q_empty[p]        = w_empty;
    assign o_drop_pulse[p]     = r_drop;
  end

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Scenario bench for snake_move_ctrl with a window-based debounce and queue reference model.
module tb_snake_move_ctrl;
  localparam int NP = 2;
  localparam int DB = 4;
  localparam int QD = 2;
  localparam int NB = 4*NP;

  logic          clk, rst, tick, enable;
  logic [NB-1:0] btn;
  logic [3*NP-1:0] dir_out;
  logic [NP-1:0] q_empty, drop_pulse;
  int nv, nf;

  snake_move_ctrl #(.NUM_PLAYERS(NP), .DEBOUNCE_CYCLES(DB), .QUEUE_DEPTH(QD), .INIT_DIR(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_btn(btn), .i_tick(tick), .i_enable(enable),
    .o_dir_out(dir_out), .o_q_empty(q_empty), .o_drop_pulse(drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raw samples delayed two edges, a level is accepted once the
  // last DB delayed samples all disagree with it; queues are plain SV queues.
  bit m_rw  [NB][$];
  bit m_win [NB][$];
  bit m_db  [NB];
  bit m_press [NB];
  int m_dir [NP];
  int m_q   [NP][$];
  bit m_drop [NP];

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_rw[b].delete(); m_rw[b].push_back(1'b0); m_rw[b].push_back(1'b0);
      m_win[b].delete(); m_db[b] = 1'b0; m_press[b] = 1'b0;
    end
    for (int p = 0; p < NP; p++) begin
      m_dir[p] = 2; m_q[p].delete(); m_drop[p] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int p = 0; p < NP; p++) begin
      m_drop[p] = 1'b0;
      if (!enable) begin
        m_q[p].delete();
      end else begin
        int req, refd, diff;
        bit pop, push;
        req = 0;
        for (int k = 0; k < 4; k++)
          if (req == 0 && m_press[4*p + 3 - k]) req = k + 1;
        refd = (m_q[p].size() > 0) ? m_q[p][$] : m_dir[p];
        pop  = tick && (m_q[p].size() > 0);
        push = 1'b0;
        diff = req - refd;
        if (req != 0 && req != refd) begin
          if (diff == 2 || diff == -2)          m_drop[p] = 1'b1;
          else if (m_q[p].size() == QD && !pop) m_drop[p] = 1'b1;
          else                                  push = 1'b1;
        end
        if (pop)  m_dir[p] = m_q[p].pop_front();
        if (push) m_q[p].push_back(req);
      end
    end
    for (int b = 0; b < NB; b++) begin
      bit sv, all_diff;
      sv = m_rw[b].pop_front();
      m_rw[b].push_back(btn[b]);
      m_win[b].push_back(sv);
      if (m_win[b].size() > DB) void'(m_win[b].pop_front());
      m_press[b] = 1'b0;
      if (m_win[b].size() == DB) begin
        all_diff = 1'b1;
        foreach (m_win[b][i]) if (m_win[b][i] == m_db[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_db[b] = ~m_db[b];
          m_press[b] = m_db[b];
        end
      end
    end
  endtask

  function automatic logic [3*NP-1:0] exp_dir();
    logic [3*NP-1:0] e;
    for (int p = 0; p < NP; p++) e[3*p +: 3] = 3'(m_dir[p]);
    return e;
  endfunction

  function automatic logic [NP-1:0] exp_qe();
    logic [NP-1:0] e;
    for (int p = 0; p < NP; p++) e[p] = (m_q[p].size() == 0);
    return e;
  endfunction

  function automatic logic [NP-1:0] exp_drop();
    logic [NP-1:0] e;
    for (int p = 0; p < NP; p++) e[p] = m_drop[p];
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1; step(); tick = 1'b0;
  endtask

  task automatic pulse_btn(input logic [NB-1:0] mask, output int d0, output int d1,
                           output logic [NP-1:0] qe_all);
    d0 = 0; d1 = 0; qe_all = '1;
    btn = btn | mask;
    for (int i = 0; i < 14; i++) begin
      if (i == 6) btn = btn & ~mask;
      step();
      d0 += int'(drop_pulse[0]);
      d1 += int'(drop_pulse[1]);
      qe_all &= q_empty;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; btn = '0; tick = 1'b0; enable = 1'b1;
    #1 rst = 1'b1;
    model_reset();
    #1;
    nv++; if (dir_out !== 6'o22) begin nf++; $display("FAIL reset_dir got=%h want=%h", dir_out, 6'o22); end
    nv++; if (q_empty !== 2'b11) begin nf++; $display("FAIL reset_qe got=%b want=11", q_empty); end
    nv++; if (drop_pulse !== 2'b00) begin nf++; $display("FAIL reset_drop got=%b want=00", drop_pulse); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_debounce();
    int first;
    btn[3] = 1'b1; repeat (3) step(); btn[3] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      nv++; if (q_empty !== 2'b11) begin nf++; $display("FAIL glitch_qe cyc=%0d got=%b want=11", i, q_empty); end
    end
    first = 0;
    btn[3] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (first == 0 && !q_empty[0]) first = n;
    end
    btn[3] = 1'b0;
    nv++; if (first != 7) begin nf++; $display("FAIL press_latency got=%0d want=7", first); end
    repeat (8) step();
    do_tick();
    nv++; if (dir_out[2:0] !== 3'd1) begin nf++; $display("FAIL tick_up got=%0d want=1", dir_out[2:0]); end
    nv++; if (dir_out !== exp_dir() || q_empty !== exp_qe()) begin
      nf++; $display("FAIL debounce_model dir=%h want=%h qe=%b want=%b", dir_out, exp_dir(), q_empty, exp_qe());
    end
  endtask

  task automatic test_reject();
    int d0, d1; logic [NP-1:0] qa;
    pulse_btn(8'h04, d0, d1, qa);
    do_tick();
    nv++; if (dir_out[2:0] !== 3'd2) begin nf++; $display("FAIL to_right got=%0d want=2", dir_out[2:0]); end
    pulse_btn(8'h01, d0, d1, qa);
    nv++; if (d0 != 1 || qa[0] !== 1'b1) begin nf++; $display("FAIL opposite pulses=%0d want=1 qe=%b want=1", d0, qa[0]); end
    pulse_btn(8'h04, d0, d1, qa);
    nv++; if (d0 != 0 || qa[0] !== 1'b1) begin nf++; $display("FAIL same_dir pulses=%0d want=0 qe=%b want=1", d0, qa[0]); end
  endtask

  task automatic test_queue_full();
    int d0, d1; logic [NP-1:0] qa;
    pulse_btn(8'h80, d0, d1, qa);
    pulse_btn(8'h10, d0, d1, qa);
    pulse_btn(8'h20, d0, d1, qa);
    nv++; if (d1 != 1 || q_empty[1] !== 1'b0) begin nf++; $display("FAIL full_drop pulses=%0d want=1 qe1=%b want=0", d1, q_empty[1]); end
    do_tick();
    nv++; if (dir_out[5:3] !== 3'd1) begin nf++; $display("FAIL p1_tick1 got=%0d want=1", dir_out[5:3]); end
    step();
    do_tick();
    nv++; if (dir_out[5:3] !== 3'd4 || q_empty[1] !== 1'b1) begin nf++; $display("FAIL p1_tick2 got=%0d want=4 qe1=%b want=1", dir_out[5:3], q_empty[1]); end
  endtask

  task automatic test_tick_push();
    int d0, d1; logic [NP-1:0] qa;
    pulse_btn(8'h08, d0, d1, qa);
    pulse_btn(8'h01, d0, d1, qa);
    btn[1] = 1'b1;
    repeat (6) step();
    tick = 1'b1; step(); tick = 1'b0;
    nv++; if (dir_out[2:0] !== 3'd1 || q_empty[0] !== 1'b0 || drop_pulse[0] !== 1'b0) begin
      nf++; $display("FAIL tick_push dir=%0d want=1 qe0=%b want=0 drop0=%b want=0", dir_out[2:0], q_empty[0], drop_pulse[0]);
    end
    btn[1] = 1'b0;
    repeat (8) step();
    enable = 1'b0; step(); enable = 1'b1;
    nv++; if (q_empty !== 2'b11 || dir_out !== {3'd4, 3'd1}) begin
      nf++; $display("FAIL flush qe=%b want=11 dir=%h want=%h", q_empty, dir_out, {3'd4, 3'd1});
    end
    nv++; if (dir_out !== exp_dir()) begin nf++; $display("FAIL flush_model dir=%h want=%h", dir_out, exp_dir()); end
  endtask

  task automatic test_priority();
    int d0, d1; logic [NP-1:0] qa;
    pulse_btn(8'h04, d0, d1, qa);
    do_tick();
    pulse_btn(8'h09, d0, d1, qa);
    nv++; if (d0 != 0 || q_empty[0] !== 1'b0 || dir_out[5:3] !== 3'd4) begin
      nf++; $display("FAIL prio_push pulses=%0d want=0 qe0=%b want=0 p1=%0d want=4", d0, q_empty[0], dir_out[5:3]);
    end
    do_tick();
    nv++; if (dir_out[2:0] !== 3'd1 || q_empty[0] !== 1'b1) begin
      nf++; $display("FAIL prio_tick dir=%0d want=1 qe0=%b want=1", dir_out[2:0], q_empty[0]);
    end
  endtask

  task automatic test_reset_mid();
    int first;
    btn = 8'h08;
    repeat (4) step();
    rst = 1'b1;
    model_reset();
    #1;
    nv++; if (dir_out !== 6'o22 || q_empty !== 2'b11 || drop_pulse !== 2'b00) begin
      nf++; $display("FAIL mid_reset dir=%h want=12 qe=%b want=11 drop=%b want=00", dir_out, q_empty, drop_pulse);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    first = 0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (first == 0 && !q_empty[0]) first = n;
    end
    btn = '0;
    nv++; if (first != 7) begin nf++; $display("FAIL held_thru_reset got=%0d want=7", first); end
    repeat (10) step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      logic bad_field;
      for (int b = 0; b < NB; b++) if ($urandom_range(0, 9) == 0) btn[b] = ~btn[b];
      tick   = ($urandom_range(0, 3) == 0);
      enable = ($urandom_range(0, 39) != 0);
      step();
      nv++;
      if (dir_out !== exp_dir() || q_empty !== exp_qe() || drop_pulse !== exp_drop()) begin
        nf++;
        $display("FAIL random cyc=%0d dir=%h want=%h qe=%b want=%b drop=%b want=%b",
                 c, dir_out, exp_dir(), q_empty, exp_qe(), drop_pulse, exp_drop());
      end
      bad_field = 1'b0;
      for (int p = 0; p < NP; p++)
        if (dir_out[3*p +: 3] < 3'd1 || dir_out[3*p +: 3] > 3'd4) bad_field = 1'b1;
      nv++; if (bad_field !== 1'b0) begin nf++; $display("FAIL dir_range cyc=%0d dir=%h", c, dir_out); end
    end
    tick = 1'b0; enable = 1'b1;
  endtask

  initial begin
    nv = 0; nf = 0;
    test_reset();
    test_debounce();
    test_reject();
    test_queue_full();
    test_tick_push();
    test_priority();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end

endmodule

// File: doc/snake_move_ctrl.md
SNAKE_MOVE_CTRL -- requirements
Module: snake_move_ctrl

Interface
REQ-001 NUM_PLAYERS, default 2: number of independent controller channels, range 1..4.
REQ-002 DEBOUNCE_CYCLES, default 500000: consecutive stable samples needed to accept a button level, range 2 or more.
REQ-003 QUEUE_DEPTH, default 2: pending-move FIFO depth per player, range 1..8.
REQ-004 INIT_DIR, default 2 (right): direction loaded on reset.
REQ-005 clock  input  1  system clock; single clock domain.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 btn  input  4*NUM_PLAYERS  raw asynchronous buttons; player p uses bits [4p+3:4p] = {up,right,down,left}.
REQ-008 tick  input  1  one-cycle game-step strobe.
REQ-009 enable  input  1  game running; low freezes moves and flushes queues.
REQ-010 dir_out  output  3*NUM_PLAYERS  current direction of player p at bits [3p+2:3p]; 1=up, 2=right, 3=down, 4=left.
REQ-011 q_empty  output  NUM_PLAYERS  player p's queue is empty.
REQ-012 drop_pulse  output  NUM_PLAYERS  one-cycle pulse when a press for player p is rejected.

Function
REQ-013 Each btn bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 The debounced level SHALL update only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-run break resets the counter.
REQ-015 A press SHALL be a 0->1 edge of the debounced level, registered one cycle after the debounced level changes.
REQ-016 Simultaneous presses for one player in the same cycle SHALL be resolved by priority up>right>down>left; the losers SHALL be discarded without drop_pulse.
REQ-017 The reference direction SHALL be the queue tail when the queue is non-empty, otherwise dir_out, both sampled before the current cycle's updates.
REQ-018 A press equal to the reference direction SHALL be ignored silently.
REQ-019 A press opposite the reference direction (codes differing by 2) SHALL be rejected, and drop_pulse SHALL assert for that player.
REQ-020 A valid press SHALL be enqueued if the queue is not full; otherwise it SHALL be rejected and drop_pulse SHALL assert.
REQ-021 On tick with enable high and a non-empty queue, dir_out SHALL load the queue head on the next edge and the head SHALL pop; on tick with an empty queue, dir_out SHALL hold.
REQ-022 When tick and a valid press occur in the same cycle, the pop and push SHALL both take effect. On a full queue, the push SHALL be accepted and the count SHALL stay unchanged. On an empty queue, the pressed move SHALL appear on the following tick, not the current one.
REQ-023 While enable is low, all queues SHALL be flushed synchronously, presses SHALL be ignored without drop_pulse, ticks SHALL be ignored, and dir_out SHALL hold; debouncers SHALL keep running.
REQ-024 dir_out SHALL never carry 0 or a code above 4; players SHALL be fully independent.
REQ-025 Latency from a raw press to enqueue SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles.

Reset
REQ-026 On reset assertion, the following SHALL apply immediately:
- every dir_out field = INIT_DIR
- q_empty = all ones
- drop_pulse = 0
- synchronizers, debounced levels and debounce counters = 0
- FIFO pointers and counts = 0
REQ-027 Reset asserted mid-debounce or mid-queue SHALL discard all pending state; a button held through reset release SHALL register as a press once debounced.

Structure
REQ-028 Direction codes (DIR_UP=1, DIR_RIGHT=2, DIR_DOWN=3, DIR_LEFT=4) and the opposite-direction function SHALL live in the shared package snake_pkg, which the snake engine also uses.
REQ-029 Synchronizer, debounce counter and edge detector for one bit SHALL form the sub-module snake_debounce, instantiated 4*NUM_PLAYERS times; counter width = clog2(DEBOUNCE_CYCLES+1).
REQ-030 The per-player queue SHALL be a circular buffer with a count register, built inside a generate loop.

Verification (DEBOUNCE_CYCLES=4, QUEUE_DEPTH=2, NUM_PLAYERS=2)
REQ-031 Reset -> dir_out=0x12 (both fields 2), q_empty=2'b11, drop_pulse=0.
REQ-032 P0 up held 3 cycles, then released -> no enqueue. P0 up held 10 cycles -> q_empty[0]=0 exactly 7 cycles after assertion; next tick -> dir_out[2:0]=1.
REQ-033 P0 at right, press left -> drop_pulse[0] for 1 cycle, queue stays empty. Press right -> no pulse, no enqueue.
REQ-034 P1 at right, presses up, then left, then down with no tick -> first two enqueued, down dropped (drop_pulse[1]). Two ticks -> dir_out[5:3]=1, then 4.
REQ-035 Full P0 queue, with tick coinciding with a valid press -> head popped to dir_out, press accepted, q_empty[0]=0, no drop. enable low 1 cycle -> q_empty=2'b11, dir_out unchanged.
REQ-036 P0 up and left pressed in the same cycle -> only up enqueued, no drop_pulse. P1 unaffected throughout.
